ffd_wr_arbiter: RTL and testbench

FFD_WR_ARBITER -- requirements
Module: ffd_wr_arbiter

---
 rtl/ffd_arb_pkg.sv | 15 +
 rtl/ffd_rr_pick.sv | 35 +++
 rtl/ffd_wr_arbiter.sv | 118 +++++++++++
 tb/tb_ffd_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ffd_arb_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter:
// FSM state encoding and parameter defaults.
package ffd_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_HOLD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ffd_rr_pick.sv
// Rotating-priority picker: first set request bit at or after ptr, wrapping
// cyclically. Purely combinational.
module ffd_rr_pick
  import ffd_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int unsigned PW = $clog2(NREQ);

  // One extra bit so ptr+off can exceed NREQ-1 before folding back.
  logic [PW:0] sum;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!any && req[sum[PW-1:0]]) begin
        any    = 1'b1;
        winner = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/ffd_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a single write into a
// shared register, followed by a fixed number of settle cycles.
module ffd_wr_arbiter #(
  parameter int unsigned NREQ = ffd_arb_pkg::DEF_NREQ,
  parameter int unsigned DW   = ffd_arb_pkg::DEF_DW,
  parameter int unsigned HOLD = ffd_arb_pkg::DEF_HOLD
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      data,
  output logic [NREQ-1:0]         gnt,
  output logic                    reg_we,
  output logic [DW-1:0]           reg_wdata,
  output logic [$clog2(NREQ)-1:0] reg_wsrc,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD);

  // States are scope-qualified: HOLD is also the settle-length parameter name.
  ffd_arb_pkg::arb_state_t state_q, state_d;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q;
  logic          cap;
  logic [PW-1:0] ptr_next;

  logic [DW-1:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign data_a[g] = data[g*DW +: DW];
  end

  ffd_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(pick_idx),
    .any   (pick_any)
  );

  assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      ffd_arb_pkg::IDLE: begin
        if (pick_any) begin
          cap     = 1'b1;
          state_d = ffd_arb_pkg::GRANT;
        end
      end
      ffd_arb_pkg::GRANT: begin
        ptr_d = ptr_next;
        if (HOLD > 0) begin
          cnt_d   = HOLD_LD;
          state_d = ffd_arb_pkg::HOLD;
        end else begin
          state_d = ffd_arb_pkg::IDLE;
        end
      end
      ffd_arb_pkg::HOLD: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ffd_arb_pkg::IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ffd_arb_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ffd_arb_pkg::IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        win_q   <= pick_idx;
        wdata_q <= data_a[pick_idx];
      end
    end
  end

  // Winner/data registers double as the write port, so they hold between grants.
  always_comb begin
    gnt = '0;
    if (state_q == ffd_arb_pkg::GRANT) begin
      gnt[win_q] = 1'b1;
    end
  end

  assign reg_we    = (state_q == ffd_arb_pkg::GRANT);
  assign reg_wdata = wdata_q;
  assign reg_wsrc  = win_q;
  assign busy      = (state_q != ffd_arb_pkg::IDLE);

endmodule

// File: tb/tb_ffd_wr_arbiter.sv
// Bench for ffd_wr_arbiter: HOLD=2 and HOLD=0 instances share stimulus and are
// compared every cycle against a cycle-budget reference model.
module tb_ffd_wr_arbiter;

  localparam int N = 4;

  logic        aclk  = 1'b0;
  logic        arstn = 1'b0;
  logic [3:0]  req   = '0;
  logic [31:0] data  = '0;

  logic [3:0]  gnt   [2];
  logic        we    [2];
  logic [7:0]  wd    [2];
  logic [1:0]  ws    [2];
  logic        bsy   [2];

  ffd_wr_arbiter #(.NREQ(4), .DW(8), .HOLD(2)) u_h2 (
    .aclk(aclk), .arstn(arstn), .req(req), .data(data),
    .gnt(gnt[0]), .reg_we(we[0]), .reg_wdata(wd[0]), .reg_wsrc(ws[0]), .busy(bsy[0])
  );

  ffd_wr_arbiter #(.NREQ(4), .DW(8), .HOLD(0)) u_h0 (
    .aclk(aclk), .arstn(arstn), .req(req), .data(data),
    .gnt(gnt[1]), .reg_we(we[1]), .reg_wdata(wd[1]), .reg_wsrc(ws[1]), .busy(bsy[1])
  );

  always #5 aclk = ~aclk;

  // Reference model: each grant reserves HOLD+2 cycles (grant + settle + idle edge).
  int         hv   [2] = '{2, 0};
  int         rem  [2];
  int         mptr [2];
  int         msrc [2];
  logic       mg   [2];
  logic [7:0] mwd  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int gsrc [2][$];
  int gcyc [2][$];

  function automatic int first_at(input logic [3:0] r, input int p);
    for (int o = 0; o < N; o++) begin
      int k;
      k = (p + o) % N;
      if (((r >> k) & 4'b0001) != 4'b0000) return k;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i]  = 0;
      mptr[i] = 0;
      msrc[i] = 0;
      mg[i]   = 1'b0;
      mwd[i]  = '0;
    end
  endtask

  task automatic model_edge();
    if (!arstn) return;
    for (int i = 0; i < 2; i++) begin
      if (rem[i] == 0 && req != 4'b0000) begin
        int w;
        w       = first_at(req, mptr[i]);
        mg[i]   = 1'b1;
        msrc[i] = w;
        mwd[i]  = 8'(data >> (8 * w));
        rem[i]  = hv[i] + 1;
        mptr[i] = (w + 1) % N;
      end else begin
        mg[i] = 1'b0;
        if (rem[i] > 0) rem[i]--;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] expg;
      expg = mg[i] ? 4'(4'b0001 << msrc[i]) : 4'b0000;
      check($sformatf("u%0d.gnt c%0d", i, cyc), 32'(gnt[i]), 32'(expg));
      check($sformatf("u%0d.we c%0d", i, cyc), 32'(we[i]), 32'(mg[i]));
      check($sformatf("u%0d.busy c%0d", i, cyc), 32'(bsy[i]), 32'(rem[i] != 0));
      check($sformatf("u%0d.wdata c%0d", i, cyc), 32'(wd[i]), 32'(mwd[i]));
      check($sformatf("u%0d.wsrc c%0d", i, cyc), 32'(ws[i]), 32'(msrc[i]));
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      if (we[i] === 1'b1) begin
        gsrc[i].push_back(int'(ws[i]));
        gcyc[i].push_back(cyc);
      end
    end
  endtask

  task automatic reset_assert();
    arstn = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      gsrc[i].delete();
      gcyc[i].delete();
    end
  endtask

  // Compares the first n logged grants of instance u with an expected order and period.
  task automatic check_order(input string tag, input int u, input int n,
                             input int ord [8], input int period);
    check({tag, ".count"}, 32'(gsrc[u].size() >= n), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k < gsrc[u].size()) begin
        check($sformatf("%s.src%0d", tag, k), 32'(gsrc[u][k]), 32'(ord[k]));
        if (k > 0)
          check($sformatf("%s.gap%0d", tag, k), 32'(gcyc[u][k] - gcyc[u][k-1]), 32'(period));
      end
    end
  endtask

  initial begin
    int ord [8];

    // Reset held with all requests asserted.
    model_reset();
    req   = 4'hF;
    data  = $urandom;
    arstn = 1'b0;
    #1;
    check_outputs();
    repeat (10) step();

    // Full contention from reset.
    arstn = 1'b1;
    clear_log();
    repeat (20) step();
    ord = '{0, 1, 2, 3, 0, 0, 0, 0};
    check_order("contend.h2", 0, 5, ord, 4);

    // Single request from requester 2.
    reset_assert();
    step();
    arstn = 1'b1;
    req   = 4'b0100;
    data  = $urandom;
    data[23:16] = 8'hA5;
    step();
    check("single.gnt", 32'(gnt[0]), 32'(4'b0100));
    check("single.we", 32'(we[0]), 32'd1);
    check("single.wdata", 32'(wd[0]), 32'hA5);
    check("single.wsrc", 32'(ws[0]), 32'd2);
    req  = 4'b0000;
    data = $urandom;
    for (int c = 2; c <= 4; c++) begin
      step();
      check($sformatf("single.busy%0d", c), 32'(bsy[0]), 32'(c <= 3));
      check($sformatf("single.nogrant%0d", c), 32'(gnt[0]), 32'd0);
    end

    // Wrap-around after requester 2: 3 must win before 0.
    clear_log();
    req = 4'b1001;
    repeat (8) step();
    ord = '{3, 0, 0, 0, 0, 0, 0, 0};
    check_order("wrap.h2", 0, 2, ord, 4);

    // Reset in the first settle cycle after a grant to requester 2.
    reset_assert();
    step();
    arstn = 1'b1;
    req   = 4'b0100;
    data  = $urandom;
    step();
    check("midrst.grant2", 32'(gnt[0]), 32'(4'b0100));
    step();
    check("midrst.inhold", 32'(bsy[0]), 32'd1);
    reset_assert();
    check("midrst.busy0", 32'(bsy[0]), 32'd0);
    step();
    arstn = 1'b1;
    req   = 4'b1010;
    data  = $urandom;
    step();
    check("midrst.grant1", 32'(gnt[0]), 32'(4'b0010));
    repeat (3) step();

    // HOLD=0 instance alternating between two requesters.
    reset_assert();
    step();
    arstn = 1'b1;
    req   = 4'b0011;
    clear_log();
    repeat (8) step();
    ord = '{0, 1, 0, 1, 0, 0, 0, 0};
    check_order("alt.h0", 1, 4, ord, 2);

    // Randomised traffic with occasional resets.
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_assert();
        step();
        arstn = 1'b1;
      end
      req  = 4'($urandom);
      data = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
